quickq_req_arbiter: RTL and testbench

- Shares one QuickQ priority queue (sorted-array BRAM plus its control FSM) among NREQ requesters.
- Round-robin arbitration, one operation in flight at a time.
- Issues single-cycle enq/deq pulses to the queue control, waits for completion, and returns a response (dequeued key or status) tagged with the requester id.
- Sits between client logic and the QuickQ control FSM.

---
 rtl/quickq_pkg.sv | 18 +
 rtl/quickq_req_arbiter_rr.sv | 38 +++
 rtl/quickq_req_arbiter.sv | 160 ++++++++++++++++
 tb/tb_quickq_req_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/quickq_pkg.sv
// Shared types and constants for the QuickQ request arbiter.
// Holds the arbiter state encoding, the op encoding seen on req_op
// and the default key width.
package quickq_pkg;

  localparam int QQ_KW = 32;

  localparam logic OP_ENQ = 1'b0;
  localparam logic OP_DEQ = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/quickq_req_arbiter_rr.sv
// rr_arbiter: round-robin requester select, searching upward from ptr+1 with wrap.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the grant is consumed.
// Ports: req[NREQ] request vector, ptr[IDW] last winner,
//        grant_oh[NREQ] one-hot winner, grant_id[IDW] winner index, any = some req set.
module rr_arbiter
  import quickq_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant_oh,
  output logic [IDW-1:0]  grant_id,
  output logic            any
);

  int unsigned idx;

  // NREQ need not be a power of two, so the wrap is an explicit modulo
  // rather than relying on IDW-bit overflow.
  always_comb begin
    grant_oh = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + 1 + k) % NREQ;
      if (!any && req[idx]) begin
        any           = 1'b1;
        grant_oh[idx] = 1'b1;
        grant_id      = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/quickq_req_arbiter.sv
// quickq_req_arbiter: shares one QuickQ priority queue among NREQ requesters, one op in flight.
// Latency: accept at cycle 0, enq/deq pulse at cycle 1, response the cycle after qq_ack
//          (cycle 2 when rejected for full/empty).
// Backpressure: req_ready only in IDLE; the response is held in RESP until rsp_ready.
// Ports: req_valid/req_ready/req_op/req_key from clients; rsp_valid/rsp_ready/rsp_id/rsp_data/rsp_err
//        back to clients; qq_enq/qq_deq/qq_din/qq_ack/qq_dout/qq_full/qq_empty to QuickQ control; busy.
// Optional build macro QQ_ARB_TIMEOUT_EN: WAIT watchdog that errors out after TMO_CYC cycles.
module quickq_req_arbiter
  import quickq_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int KW      = QQ_KW,
  parameter int TMO_CYC = 1024,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ-1:0]     req_op,
  input  logic [NREQ*KW-1:0]  req_key,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [KW-1:0]       rsp_data,
  output logic                rsp_err,
  output logic                qq_enq,
  output logic                qq_deq,
  output logic [KW-1:0]       qq_din,
  input  logic                qq_ack,
  input  logic [KW-1:0]       qq_dout,
  input  logic                qq_full,
  input  logic                qq_empty,
  output logic                busy
);

  arb_state_t      state, state_n;
  logic            op_q;
  logic [KW-1:0]   key_q;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  rr_ptr;
  logic [KW-1:0]   data_q;
  logic            err_q;

  logic [NREQ-1:0] grant_oh;
  logic [IDW-1:0]  grant_id;
  logic            any;
  logic            reject;
  logic            tmo_hit;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req      (req_valid),
    .ptr      (rr_ptr),
    .grant_oh (grant_oh),
    .grant_id (grant_id),
    .any      (any)
  );

  // Status is sampled in ISSUE, right before the pulse would go out.
  assign reject = (op_q == OP_ENQ) ? qq_full : qq_empty;

`ifdef QQ_ARB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
  logic [15:0] tmo_cnt;

  // Zero on the first WAIT cycle, counts once per WAIT cycle after that.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == WAIT) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end else begin
      tmo_cnt <= '0;
    end
  end

  assign tmo_hit = (tmo_cnt == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_n   = state;
    req_ready = '0;
    qq_enq    = 1'b0;
    qq_deq    = 1'b0;
    case (state)
      IDLE: begin
        req_ready = grant_oh;
        if (any) state_n = ISSUE;
      end
      ISSUE: begin
        if (reject) begin
          state_n = RESP;
        end else begin
          qq_enq  = (op_q == OP_ENQ);
          qq_deq  = (op_q == OP_DEQ);
          state_n = WAIT;
        end
      end
      WAIT: begin
        // Ack is checked first so it wins over a same-cycle timeout.
        if (qq_ack || tmo_hit) state_n = RESP;
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_q   <= OP_ENQ;
      key_q  <= '0;
      id_q   <= '0;
      rr_ptr <= IDW'(NREQ - 1);
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (any) begin
            op_q  <= req_op[grant_id];
            key_q <= req_key[int'(grant_id)*KW +: KW];
            id_q  <= grant_id;
          end
        end
        ISSUE: begin
          data_q <= '0;
          err_q  <= reject;
        end
        WAIT: begin
          if (qq_ack) begin
            data_q <= (op_q == OP_DEQ) ? qq_dout : '0;
            err_q  <= 1'b0;
          end else if (tmo_hit) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) rr_ptr <= id_q;
        end
        default: ;
      endcase
    end
  end

  // Response fields read as zero outside RESP so a freshly reset block shows all-zero outputs.
  assign rsp_valid = (state == RESP);
  assign rsp_id    = rsp_valid ? id_q   : '0;
  assign rsp_data  = rsp_valid ? data_q : '0;
  assign rsp_err   = rsp_valid ? err_q  : 1'b0;
  assign qq_din    = key_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_quickq_req_arbiter.sv
module tb_quickq_req_arbiter;

  localparam int NREQ = 4;
  localparam int KW   = 32;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   req_op;
  logic [NREQ*KW-1:0] req_key;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [KW-1:0]     rsp_data;
  logic              rsp_err;
  logic              qq_enq, qq_deq;
  logic [KW-1:0]     qq_din;
  logic              qq_ack;
  logic [KW-1:0]     qq_dout;
  logic              qq_full, qq_empty;
  logic              busy;

  int total = 0;
  int bad   = 0;

  quickq_req_arbiter #(.NREQ(NREQ), .KW(KW), .TMO_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .qq_enq(qq_enq), .qq_deq(qq_deq), .qq_din(qq_din), .qq_ack(qq_ack), .qq_dout(qq_dout),
    .qq_full(qq_full), .qq_empty(qq_empty), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one cycle and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_op = '0; req_key = '0; rsp_ready = 1'b0;
    qq_ack = 1'b0; qq_dout = '0; qq_full = 1'b0; qq_empty = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h want=0", busy); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%0h want=0", rsp_valid); end
    total++; if ({qq_enq, qq_deq} !== 2'b00) begin bad++; $display("FAIL rst_pulses got=%0b want=00", {qq_enq, qq_deq}); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rst_req_ready got=%0b want=0000", req_ready); end
    total++; if ({rsp_id, rsp_data, rsp_err, qq_din} !== '0) begin bad++; $display("FAIL rst_outputs got nonzero want=0"); end
  endtask

  task automatic test_single_enq();
    do_reset();
    req_valid = 4'b0100; req_op = 4'b0000; req_key[2*KW +: KW] = 32'h10;
    #1;
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL se_grant got=%0b want=0100", req_ready); end
    tick(); req_valid = '0; // cycle 1 ISSUE
    total++; if ({qq_enq, qq_deq} !== 2'b10) begin bad++; $display("FAIL se_pulse got=%0b want=10", {qq_enq, qq_deq}); end
    total++; if (qq_din !== 32'h10) begin bad++; $display("FAIL se_din got=%0h want=10", qq_din); end
    tick(); // cycle 2 WAIT
    total++; if ({qq_enq, qq_deq} !== 2'b00) begin bad++; $display("FAIL se_pulse_len got=%0b want=00", {qq_enq, qq_deq}); end
    total++; if (qq_din !== 32'h10) begin bad++; $display("FAIL se_din_hold got=%0h want=10", qq_din); end
    tick(); // cycle 3
    tick(); qq_ack = 1'b1; qq_dout = 32'hABCD; // cycle 4 ack
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL se_early_rsp got=%0h want=0", rsp_valid); end
    tick(); qq_ack = 1'b0; rsp_ready = 1'b1; // cycle 5
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL se_rsp_valid got=%0h want=1", rsp_valid); end
    total++; if (rsp_id !== 2'd2) begin bad++; $display("FAIL se_rsp_id got=%0d want=2", rsp_id); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL se_rsp_err got=%0h want=0", rsp_err); end
    total++; if (rsp_data !== 32'h0) begin bad++; $display("FAIL se_rsp_data got=%0h want=0", rsp_data); end
    tick(); rsp_ready = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL se_idle got=%0h want=0", busy); end
  endtask

  task automatic test_round_robin();
    int exp_id [6] = '{0, 1, 3, 0, 1, 3};
    logic [NREQ-1:0] exp_oh;
    do_reset();
    for (int i = 0; i < NREQ; i++) req_key[i*KW +: KW] = 32'h100 + i;
    req_valid = 4'b1011; rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 6; n++) begin
      exp_oh = '0; exp_oh[exp_id[n]] = 1'b1;
      total++; if (req_ready !== exp_oh) begin bad++; $display("FAIL rr_grant%0d got=%0b want=%0b", n, req_ready, exp_oh); end
      tick(); // ISSUE
      total++; if (qq_enq !== 1'b1 || qq_din !== 32'h100 + exp_id[n]) begin bad++; $display("FAIL rr_issue%0d got=%0h/%0h want=1/%0h", n, qq_enq, qq_din, 32'h100 + exp_id[n]); end
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rr_busy_ready%0d got=%0b want=0000", n, req_ready); end
      tick(); qq_ack = 1'b1; // WAIT
      tick(); qq_ack = 1'b0; // RESP
      total++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(exp_id[n])) begin bad++; $display("FAIL rr_rsp%0d got=%0h/%0d want=1/%0d", n, rsp_valid, rsp_id, exp_id[n]); end
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL rr_resp_ready%0d got=%0b want=0000", n, req_ready); end
      tick(); // back to IDLE
    end
    req_valid = '0; rsp_ready = 1'b0;
  endtask

  task automatic test_reject();
    do_reset();
    qq_empty = 1'b1; req_op = 4'b0010; req_valid = 4'b0010; rsp_ready = 1'b0;
    #1;
    total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL rj_grant got=%0b want=0010", req_ready); end
    tick(); req_valid = '0; // cycle 1
    total++; if ({qq_enq, qq_deq} !== 2'b00) begin bad++; $display("FAIL rj_deq_pulse got=%0b want=00", {qq_enq, qq_deq}); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rj_early got=%0h want=0", rsp_valid); end
    tick(); // cycle 2
    total++; if ({rsp_valid, rsp_err, rsp_id} !== {1'b1, 1'b1, 2'd1} || rsp_data !== '0) begin bad++; $display("FAIL rj_deq_rsp got=%0b_%0b_%0d_%0h want=1_1_1_0", rsp_valid, rsp_err, rsp_id, rsp_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    qq_empty = 1'b0; qq_full = 1'b1; req_op = 4'b0000; req_valid = 4'b1000; req_key[3*KW +: KW] = 32'h33;
    tick(); req_valid = '0; // ISSUE
    total++; if ({qq_enq, qq_deq} !== 2'b00) begin bad++; $display("FAIL rj_enq_pulse got=%0b want=00", {qq_enq, qq_deq}); end
    tick();
    total++; if ({rsp_valid, rsp_err, rsp_id} !== {1'b1, 1'b1, 2'd3} || rsp_data !== '0) begin bad++; $display("FAIL rj_enq_rsp got=%0b_%0b_%0d_%0h want=1_1_3_0", rsp_valid, rsp_err, rsp_id, rsp_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0; qq_full = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req_op = 4'b0001; req_valid = 4'b0001; rsp_ready = 1'b0;
    tick(); req_valid = '0; // ISSUE
    total++; if (qq_deq !== 1'b1) begin bad++; $display("FAIL bp_deq got=%0h want=1", qq_deq); end
    tick(); qq_ack = 1'b1; qq_dout = 32'h5; // WAIT
    tick(); qq_ack = 1'b0; qq_dout = 32'hDEAD; req_valid = 4'b0010; req_op = 4'b0000; // RESP
    for (int c = 0; c < 4; c++) begin
      total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h5) begin bad++; $display("FAIL bp_hold%0d got=%0h/%0h want=1/5", c, rsp_valid, rsp_data); end
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready%0d got=%0b want=0000", c, req_ready); end
      tick();
    end
    rsp_ready = 1'b1; #1;
    total++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h5) begin bad++; $display("FAIL bp_final got=%0h/%0h want=1/5", rsp_valid, rsp_data); end
    tick(); rsp_ready = 1'b0; // IDLE
    total++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin bad++; $display("FAIL bp_next got=%0h/%0b want=0/0010", rsp_valid, req_ready); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    req_op = 4'b0000; req_valid = 4'b0100;
    tick(); req_valid = '0; // ISSUE
    tick(); // WAIT
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rw_in_wait got=%0h want=1", busy); end
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if ({busy, rsp_valid, qq_enq, qq_deq} !== 4'b0000 || req_ready !== '0) begin bad++; $display("FAIL rw_reset got=%0b want=0000", {busy, rsp_valid, qq_enq, qq_deq}); end
    qq_ack = 1'b1; tick(); qq_ack = 1'b0;
    total++; if ({busy, rsp_valid} !== 2'b00) begin bad++; $display("FAIL rw_stray_ack got=%0b want=00", {busy, rsp_valid}); end
    req_valid = 4'b1111; #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rw_first_grant got=%0b want=0001", req_ready); end
    req_valid = '0;
  endtask

`ifdef QQ_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req_op = 4'b0000; req_valid = 4'b0001;
    tick(); req_valid = '0; // ISSUE, cycle 1
    tick(); // WAIT entry, cycle 2
    for (int c = 0; c < 8; c++) begin
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL to_early%0d got=%0h want=0", c, rsp_valid); end
      tick();
    end
    total++; if ({rsp_valid, rsp_err} !== 2'b11 || rsp_data !== '0) begin bad++; $display("FAIL to_expire got=%0b/%0h want=11/0", {rsp_valid, rsp_err}, rsp_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    req_op = 4'b0001; req_valid = 4'b0001;
    tick(); req_valid = '0;
    tick(); // WAIT entry
    for (int c = 0; c < 7; c++) tick();
    qq_ack = 1'b1; qq_dout = 32'h77; // 8th WAIT cycle
    tick(); qq_ack = 1'b0;
    total++; if ({rsp_valid, rsp_err} !== 2'b10 || rsp_data !== 32'h77) begin bad++; $display("FAIL to_ack_wins got=%0b/%0h want=10/77", {rsp_valid, rsp_err}, rsp_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_enq();
    test_round_robin();
    test_reject();
    test_backpressure();
    test_reset_mid_wait();
`ifdef QQ_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
